// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory between fetch (I) and data (D) ports.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_d;
  logic          r_win_d;
  logic          w_gnt_i;
  logic          w_gnt_d;
  // On a tie the port that did not win the last contested grant goes first.
  assign w_gnt_i = i_req & (~d_req | r_last_d);
  assign w_gnt_d = d_req & ~w_gnt_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last_d  <= 1'b1;
      r_win_d   <= 1'b0;
      i_done    <= 1'b0;
      i_rdata   <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_i || w_gnt_d) begin
          r_state   <= ACCESS;
          r_cnt     <= CW'(1);
          mem_en    <= 1'b1;
          busy      <= 1'b1;
          mem_we    <= w_gnt_d & d_we;
          mem_addr  <= w_gnt_d ? d_addr : i_addr;
          mem_wdata <= w_gnt_d ? d_wdata : '0;
          r_win_d   <= w_gnt_d;
          if (i_req && d_req) r_last_d <= w_gnt_d;
        end
        ACCESS: begin
          mem_en <= 1'b0;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(MEM_LAT)) begin
            r_state <= RESP;
            if (r_win_d) begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a 2-cycle behavioural memory.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_done;
  logic [63:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        busy;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] wmem [0:511];
  bit          wr   [0:511];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input logic [8:0] a);
    return a == 9'h040 ? 64'hA5 : a == 9'h080 ? 64'h77 : 64'h0;
  endfunction

  // Address registered one edge after mem_en; data valid for the capture edge E+2.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr[8:0]] <= mem_wdata;
      wr[mem_addr[8:0]]   <= 1'b1;
    end
    mem_rdata <= wr[mem_addr[8:0]] ? wmem[mem_addr[8:0]] : init_word(mem_addr[8:0]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    nc(2);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_i_rdata", i_rdata, 0);
    rst = 1'b0;
    // 1: reset mid-access
    i_req = 1'b1; i_addr = 32'h40;
    nc(1);
    chk("r1_mem_en", mem_en, 1);
    chk("r1_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("r1_async_en", mem_en, 0);
    chk("r1_async_busy", busy, 0);
    chk("r1_async_addr", mem_addr, 0);
    nc(2);
    chk("r1_no_done", i_done, 0);
    rst = 1'b0;
    // 2: lone fetch
    nc(1);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_we", mem_we, 0);
    chk("f_addr", mem_addr, 32'h40);
    nc(1);
    chk("f_en_drop", mem_en, 0);
    chk("f_done_early", i_done, 0);
    nc(1);
    chk("f_i_done", i_done, 1);
    chk("f_i_rdata", i_rdata, 64'hA5);
    chk("f_d_done", d_done, 0);
    i_req = 1'b0;
    nc(1);
    chk("f_done_drop", i_done, 0);
    chk("f_busy_low", busy, 0);
    // 3: contention straight out of reset
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    nc(1);
    rst = 1'b0;
    nc(1);
    chk("c_first_I", mem_addr, 32'h40);
    nc(2);
    chk("c_i_done", i_done, 1);
    chk("c_d_quiet", d_done, 0);
    i_req = 1'b0;
    nc(1);
    chk("c_gap_busy", busy, 0);
    chk("c_gap_d_done", d_done, 0);
    nc(1);
    chk("c_D_grant_en", mem_en, 1);
    chk("c_D_grant_addr", mem_addr, 32'h80);
    nc(2);
    chk("c_d_done", d_done, 1);
    chk("c_i_quiet", i_done, 0);
    chk("c_d_rdata", d_rdata, 64'h77);
    d_req = 1'b0;
    nc(1);
    // 4: store then load
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 64'hDEAD;
    nc(1);
    chk("s_mem_we", mem_we, 1);
    chk("s_wdata", mem_wdata, 64'hDEAD);
    chk("s_addr", mem_addr, 32'h100);
    nc(2);
    chk("s_d_done", d_done, 1);
    chk("s_rdata_kept", d_rdata, 64'h77);
    d_req = 1'b0;
    nc(1);
    chk("s_we_drop", mem_we, 0);
    d_req = 1'b1; d_we = 1'b0;
    nc(1);
    chk("l_mem_we", mem_we, 0);
    chk("l_mem_en", mem_en, 1);
    nc(2);
    chk("l_d_done", d_done, 1);
    chk("l_d_rdata", d_rdata, 64'hDEAD);
    d_req = 1'b0;
    nc(1);
    // 5: fairness with both requests held
    rst = 1'b1;
    i_addr = 32'h40; d_addr = 32'h80; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    nc(1);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nc(1);
      chk("rr_en", mem_en, 1);
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h40 : 32'h80);
      chk("rr_we", mem_we, 0);
      nc(2);
      chk("rr_i_done", i_done, (k % 2 == 0) ? 1 : 0);
      chk("rr_d_done", d_done, (k % 2 == 0) ? 0 : 1);
      nc(1);
      chk("rr_gap", busy, 0);
    end
    i_req = 1'b0; d_req = 1'b0;
    nc(1);
    chk("rr_idle", busy, 0);
    // 6: late D arrival during a fetch
    i_req = 1'b1; i_addr = 32'h40;
    nc(1);
    chk("la_I_grant", mem_addr, 32'h40);
    d_req = 1'b1; d_addr = 32'h80;
    nc(1);
    chk("la_wait", mem_addr, 32'h40);
    nc(1);
    chk("la_i_done", i_done, 1);
    i_req = 1'b0;
    d_addr = 32'h100;
    nc(1);
    chk("la_gap", busy, 0);
    nc(1);
    chk("la_D_en", mem_en, 1);
    chk("la_D_addr", mem_addr, 32'h100);
    nc(2);
    chk("la_d_done", d_done, 1);
    chk("la_d_rdata", d_rdata, 64'hDEAD);
    d_req = 1'b0;
    nc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
